lsu_riscv: RTL and testbench

- Load-store unit between the core datapath and the data-memory port.
- Consumes the decoder's memory-request controls (request, write-enable, 3-bit size) together with the ALU-computed address and the rs2 store data.
- Runs a multi-cycle gnt/rvalid transaction on the memory bus.
- Drives lsu_stall_req_o, which the decoder turns into enpc and GPR write gating.
- Returns sign- or zero-extended load data for writeback.

---
 rtl/lsu_riscv.sv | 181 ++++++++++++++++++
 tb/tb_lsu_riscv.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/lsu_riscv.sv
// lsu_riscv: load-store unit between the core datapath and the data-memory bus.
// Accepts a decoded memory request, formats store data/byte enables, runs a
// req/gnt then rvalid transaction, and returns the extended load result.
//
// Ports:
//   clk_i, rst_i            clock, synchronous active-high reset
//   lsu_req_i/we_i/size_i   memory op request, store flag, LDST size code
//   lsu_addr_i, lsu_data_i  byte address, store data (rs2)
//   lsu_stall_req_o         hold PC / GPR write until the op completes
//   lsu_data_o, lsu_err_o   load result and error pulse, valid in DONE
//   data_*                  memory bus (req/we/be/addr/wdata out, gnt/rvalid/rdata in)
module lsu_riscv #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        lsu_req_i,
  input  logic        lsu_we_i,
  input  logic [2:0]  lsu_size_i,
  input  logic [31:0] lsu_addr_i,
  input  logic [31:0] lsu_data_i,
  output logic        lsu_stall_req_o,
  output logic [31:0] lsu_data_o,
  output logic        lsu_err_o,
  output logic        data_req_o,
  output logic        data_we_o,
  output logic [3:0]  data_be_o,
  output logic [31:0] data_addr_o,
  output logic [31:0] data_wdata_o,
  input  logic        data_gnt_i,
  input  logic        data_rvalid_i,
  input  logic [31:0] data_rdata_i
);

  localparam int unsigned CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {IDLE, REQ, RESP, DONE} state_t;

  state_t            state, state_nxt;
  logic              we_q;
  logic [2:0]        size_q;
  logic [1:0]        off_q;
  logic              err_q;
  logic [CNT_W-1:0]  tmo_cnt;

  logic              req_bad;
  logic [3:0]        fmt_be;
  logic [31:0]       fmt_wdata;
  logic              tmo_hit;
  logic              load_done;
  logic              tmo_done;

  function automatic logic [31:0] load_ext(input logic [31:0] w,
                                           input logic [2:0]  sz,
                                           input logic [1:0]  off);
    logic [7:0]  b;
    logic [15:0] h;
    b = w[{off, 3'b000} +: 8];
    h = off[1] ? w[31:16] : w[15:0];
    case (sz)
      3'b000:  load_ext = {{24{b[7]}}, b};
      3'b100:  load_ext = {24'd0, b};
      3'b001:  load_ext = {{16{h[15]}}, h};
      3'b101:  load_ext = {16'd0, h};
      default: load_ext = w;
    endcase
  endfunction

  // Request decode: alignment/size legality and store lane formatting
  always_comb begin
    req_bad   = 1'b0;
    fmt_be    = 4'b1111;
    fmt_wdata = lsu_data_i;
    case (lsu_size_i)
      3'b000, 3'b100: req_bad = 1'b0;
      3'b001, 3'b101: req_bad = lsu_addr_i[0];
      3'b010:         req_bad = |lsu_addr_i[1:0];
      default:        req_bad = 1'b1;
    endcase
    case (lsu_size_i[1:0])
      2'b00: begin
        fmt_be    = 4'b0001 << lsu_addr_i[1:0];
        fmt_wdata = {4{lsu_data_i[7:0]}};
      end
      2'b01: begin
        fmt_be    = lsu_addr_i[1] ? 4'b1100 : 4'b0011;
        fmt_wdata = {2{lsu_data_i[15:0]}};
      end
      default: ;
    endcase
  end

  // Counter holds cycles already spent in the current REQ/RESP visit, so the
  // abort fires on the TIMEOUT-th cycle. A bus event in that cycle still wins.
  always_comb begin
    tmo_hit = (TIMEOUT != 32'd0) && ((32'(tmo_cnt) + 32'd1) == 32'(TIMEOUT));
  end

  always_comb begin
    state_nxt = state;
    load_done = 1'b0;
    tmo_done  = 1'b0;
    case (state)
      IDLE: begin
        if (lsu_req_i) state_nxt = req_bad ? DONE : REQ;
      end
      REQ: begin
        if (data_gnt_i) begin
          if (we_q) begin
            state_nxt = DONE;
          end else if (data_rvalid_i) begin
            state_nxt = DONE;
            load_done = 1'b1;
          end else begin
            state_nxt = RESP;
          end
        end else if (tmo_hit) begin
          state_nxt = DONE;
          tmo_done  = 1'b1;
        end
      end
      RESP: begin
        if (data_rvalid_i) begin
          state_nxt = DONE;
          load_done = 1'b1;
        end else if (tmo_hit) begin
          state_nxt = DONE;
          tmo_done  = 1'b1;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      we_q         <= 1'b0;
      size_q       <= '0;
      off_q        <= '0;
      err_q        <= 1'b0;
      tmo_cnt      <= '0;
      lsu_data_o   <= '0;
      data_we_o    <= 1'b0;
      data_be_o    <= '0;
      data_addr_o  <= '0;
      data_wdata_o <= '0;
    end else begin
      if (state == IDLE && lsu_req_i) begin
        we_q         <= lsu_we_i;
        size_q       <= lsu_size_i;
        off_q        <= lsu_addr_i[1:0];
        err_q        <= req_bad;
        data_we_o    <= lsu_we_i;
        data_be_o    <= fmt_be;
        data_addr_o  <= {lsu_addr_i[31:2], 2'b00};
        data_wdata_o <= fmt_wdata;
        if (req_bad) lsu_data_o <= '0;
      end
      if ((state == REQ || state == RESP) && state_nxt == state)
        tmo_cnt <= tmo_cnt + CNT_W'(1);
      else
        tmo_cnt <= '0;
      if (load_done) lsu_data_o <= load_ext(data_rdata_i, size_q, off_q);
      if (tmo_done) begin
        err_q      <= 1'b1;
        lsu_data_o <= '0;
      end
    end
  end

  assign data_req_o      = (state == REQ);
  assign lsu_stall_req_o = lsu_req_i && (state != DONE);
  assign lsu_err_o       = (state == DONE) && err_q;

endmodule

// File: tb/tb_lsu_riscv.sv
module tb_lsu_riscv;
  localparam int unsigned T = 4;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        lsu_req_i, lsu_we_i;
  logic [2:0]  lsu_size_i;
  logic [31:0] lsu_addr_i, lsu_data_i;
  logic        lsu_stall_req_o, lsu_err_o;
  logic [31:0] lsu_data_o;
  logic        data_req_o, data_we_o;
  logic [3:0]  data_be_o;
  logic [31:0] data_addr_o, data_wdata_o;
  logic        data_gnt_i, data_rvalid_i;
  logic [31:0] data_rdata_i;

  lsu_riscv #(.TIMEOUT(T)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .lsu_req_i(lsu_req_i), .lsu_we_i(lsu_we_i), .lsu_size_i(lsu_size_i),
    .lsu_addr_i(lsu_addr_i), .lsu_data_i(lsu_data_i),
    .lsu_stall_req_o(lsu_stall_req_o), .lsu_data_o(lsu_data_o), .lsu_err_o(lsu_err_o),
    .data_req_o(data_req_o), .data_we_o(data_we_o), .data_be_o(data_be_o),
    .data_addr_o(data_addr_o), .data_wdata_o(data_wdata_o),
    .data_gnt_i(data_gnt_i), .data_rvalid_i(data_rvalid_i), .data_rdata_i(data_rdata_i)
  );

  always #5 clk = ~clk;

  int unsigned n_chk = 0;
  int unsigned n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit ref_bad(input logic [2:0] sz, input logic [31:0] a);
    case (sz)
      3'd0, 3'd4: return 1'b0;
      3'd1, 3'd5: return (a % 2) != 0;
      3'd2:       return (a % 4) != 0;
      default:    return 1'b1;
    endcase
  endfunction

  function automatic logic [3:0] ref_be(input logic [2:0] sz, input logic [31:0] a);
    int unsigned off = a % 4;
    int unsigned k   = sz % 4;
    if (k == 0) return 4'(1 << off);
    if (k == 1) return (off >= 2) ? 4'hC : 4'h3;
    return 4'hF;
  endfunction

  function automatic logic [31:0] ref_wdata(input logic [2:0] sz, input logic [31:0] d);
    int unsigned k = sz % 4;
    if (k == 0) return (d & 32'hFF) * 32'h0101_0101;
    if (k == 1) return (d & 32'hFFFF) * 32'h0001_0001;
    return d;
  endfunction

  function automatic logic [31:0] ref_load(input logic [2:0] sz, input logic [31:0] a,
                                           input logic [31:0] w);
    int unsigned off = a % 4;
    logic [31:0] v;
    case (sz)
      3'd0, 3'd4: begin
        v = (w >> (8 * off)) & 32'hFF;
        if (sz == 3'd0 && v >= 32'h80) v = v | 32'hFFFF_FF00;
      end
      3'd1, 3'd5: begin
        v = (w >> (16 * (off / 2))) & 32'hFFFF;
        if (sz == 3'd1 && v >= 32'h8000) v = v | 32'hFFFF_0000;
      end
      default: v = w;
    endcase
    return v;
  endfunction

  // One complete operation. gd = gnt-low cycles before gnt; rvd = 0 means
  // rvalid together with gnt, k>0 means rvalid on the k-th response cycle.
  // keep = lsu_req_i level held after the accept cycle.
  task automatic run_op(input bit we, input logic [2:0] sz, input logic [31:0] a,
                        input logic [31:0] wd, input logic [31:0] rd,
                        input int gd, input int rvd, input bit keep);
    bit bad = ref_bad(sz, a);
    bit tmo = 1'b0;
    bit data_known;
    logic [31:0] exp_data;

    lsu_req_i = 1'b1; lsu_we_i = we; lsu_size_i = sz; lsu_addr_i = a; lsu_data_i = wd;
    data_gnt_i = 1'b0; data_rvalid_i = 1'b0;
    #1;
    check_eq("stall_accept", 32'(lsu_stall_req_o), 32'd1);
    check_eq("req_idle", 32'(data_req_o), 32'd0);
    @(posedge clk); #1;
    lsu_req_i = keep; lsu_addr_i = $urandom; lsu_data_i = $urandom; lsu_size_i = 3'($urandom);

    if (!bad) begin
      for (int i = 0; i < int'(T); i++) begin
        data_gnt_i    = (i == gd);
        data_rvalid_i = (i == gd) ? (!we && rvd == 0) : 1'($urandom_range(0, 1));
        data_rdata_i  = (i == gd && rvd == 0) ? rd : $urandom;
        #1;
        check_eq("req_high", 32'(data_req_o), 32'd1);
        check_eq("bus_addr", data_addr_o, {a[31:2], 2'b00});
        check_eq("bus_we", 32'(data_we_o), 32'(we));
        check_eq("bus_be", 32'(data_be_o), 32'(ref_be(sz, a)));
        if (we) check_eq("bus_wdata", data_wdata_o, ref_wdata(sz, wd));
        check_eq("stall_req", 32'(lsu_stall_req_o), 32'(keep));
        @(posedge clk); #1;
        if (i == gd) break;
      end
      if (gd >= int'(T)) begin
        tmo = 1'b1;
      end else if (!we && rvd != 0) begin
        for (int j = 1; j <= int'(T); j++) begin
          data_gnt_i    = 1'b0;
          data_rvalid_i = (j == rvd);
          data_rdata_i  = (j == rvd) ? rd : $urandom;
          #1;
          check_eq("req_resp", 32'(data_req_o), 32'd0);
          check_eq("stall_resp", 32'(lsu_stall_req_o), 32'(keep));
          @(posedge clk); #1;
          if (j == rvd) break;
        end
        if (rvd > int'(T)) tmo = 1'b1;
      end
    end

    // DONE cycle; lsu_req_i high here must not start a new op
    data_gnt_i = 1'b0; data_rvalid_i = 1'b0; lsu_req_i = 1'b1;
    #1;
    data_known = tmo || (!we && !bad);
    exp_data   = tmo ? 32'd0 : ref_load(sz, a, rd);
    check_eq("stall_done", 32'(lsu_stall_req_o), 32'd0);
    check_eq("err_done", 32'(lsu_err_o), 32'(bad || tmo));
    check_eq("req_done", 32'(data_req_o), 32'd0);
    if (data_known) check_eq("data_done", lsu_data_o, exp_data);
    @(posedge clk); #1;
    lsu_req_i = 1'b0;
    #1;
    check_eq("no_accept_in_done", 32'(data_req_o), 32'd0);
    check_eq("err_after", 32'(lsu_err_o), 32'd0);
    if (data_known) check_eq("data_hold", lsu_data_o, exp_data);
    @(posedge clk); #1;
  endtask

  initial begin
    logic [2:0] sizes [7];
    sizes = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd3, 3'd6};

    rst_i = 1'b1; lsu_req_i = 1'b0; lsu_we_i = 1'b0; lsu_size_i = '0;
    lsu_addr_i = '0; lsu_data_i = '0;
    data_gnt_i = 1'b0; data_rvalid_i = 1'b0; data_rdata_i = '0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_req", 32'(data_req_o), 32'd0);
    check_eq("rst_we", 32'(data_we_o), 32'd0);
    check_eq("rst_be", 32'(data_be_o), 32'd0);
    check_eq("rst_addr", data_addr_o, 32'd0);
    check_eq("rst_wdata", data_wdata_o, 32'd0);
    check_eq("rst_err", 32'(lsu_err_o), 32'd0);
    check_eq("rst_data", lsu_data_o, 32'd0);
    check_eq("rst_stall", 32'(lsu_stall_req_o), 32'd0);
    rst_i = 1'b0;
    @(posedge clk); #1;

    run_op(1'b0, 3'd2, 32'h100, 32'h0, 32'hDEADBEEF, 0, 2, 1'b1);
    run_op(1'b0, 3'd0, 32'h103, 32'h0, 32'h80FF_FF7F, 1, 1, 1'b1);
    run_op(1'b0, 3'd4, 32'h103, 32'h0, 32'h80FF_FF7F, 0, 1, 1'b1);
    run_op(1'b0, 3'd1, 32'h102, 32'h0, 32'h80FF_FF7F, 0, 3, 1'b1);
    run_op(1'b1, 3'd0, 32'h202, 32'h1234_56AB, 32'h0, 3, 0, 1'b1);
    run_op(1'b1, 3'd1, 32'h206, 32'h1234_56AB, 32'h0, 0, 0, 1'b1);
    run_op(1'b0, 3'd2, 32'h101, 32'h0, 32'h0, 0, 1, 1'b1);
    run_op(1'b0, 3'd3, 32'h100, 32'h0, 32'h0, 0, 1, 1'b1);
    run_op(1'b0, 3'd2, 32'h104, 32'h0, 32'h1111_2222, 0, 99, 1'b1);
    run_op(1'b1, 3'd2, 32'h108, 32'hCAFE_F00D, 32'h0, 9, 0, 1'b1);
    run_op(1'b0, 3'd5, 32'h10E, 32'h0, 32'hF00D_1234, 2, 0, 1'b1);
    run_op(1'b0, 3'd2, 32'h110, 32'h0, 32'h0BAD_CAFE, 3, 4, 1'b0);

    // Reset while waiting for rvalid
    lsu_req_i = 1'b1; lsu_we_i = 1'b0; lsu_size_i = 3'd2; lsu_addr_i = 32'h300;
    @(posedge clk); #1;
    data_gnt_i = 1'b1;
    @(posedge clk); #1;
    data_gnt_i = 1'b0; rst_i = 1'b1; lsu_req_i = 1'b0;
    @(posedge clk); #1;
    check_eq("mid_rst_req", 32'(data_req_o), 32'd0);
    check_eq("mid_rst_addr", data_addr_o, 32'd0);
    check_eq("mid_rst_be", 32'(data_be_o), 32'd0);
    check_eq("mid_rst_err", 32'(lsu_err_o), 32'd0);
    check_eq("mid_rst_data", lsu_data_o, 32'd0);
    rst_i = 1'b0; data_rvalid_i = 1'b1; data_rdata_i = 32'h5555_AAAA;
    @(posedge clk); #1;
    data_rvalid_i = 1'b0;
    #1;
    check_eq("late_rvalid_err", 32'(lsu_err_o), 32'd0);
    check_eq("late_rvalid_data", lsu_data_o, 32'd0);
    check_eq("late_rvalid_req", 32'(data_req_o), 32'd0);
    @(posedge clk); #1;

    for (int n = 0; n < 80; n++) begin
      bit we = ($urandom_range(0, 3) == 0);
      logic [2:0] sz = we ? sizes[$urandom_range(0, 2)] : sizes[$urandom_range(0, 6)];
      run_op(we, sz, $urandom, $urandom, $urandom,
             int'($urandom_range(0, 5)), int'($urandom_range(0, 5)), 1'($urandom_range(0, 1)));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
